// File: rtl/mc_controller_ws_pkg.sv
// Shared types and constants for the multicycle ARM controller: FSM states,
// ALU operation codes, data-processing command codes and condition evaluation.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_MULEX  = 4'd10,
      S_MULWB  = 4'd11
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_MUL = 3'b100
   } alu_ctrl_e;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // nzcv is {N, Z, C, V}; the reserved 1111 code never executes.
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: cond_check = z;
         COND_NE: cond_check = ~z;
         COND_CS: cond_check = c;
         COND_CC: cond_check = ~c;
         COND_MI: cond_check = n;
         COND_PL: cond_check = ~n;
         COND_VS: cond_check = v;
         COND_VC: cond_check = ~v;
         COND_HI: cond_check = c & ~z;
         COND_LS: cond_check = ~c | z;
         COND_GE: cond_check = (n == v);
         COND_LT: cond_check = (n != v);
         COND_GT: cond_check = ~z & (n == v);
         COND_LE: cond_check = z | (n != v);
         COND_AL: cond_check = 1'b1;
         default: cond_check = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_ws_if.sv
// Controller-to-datapath bundle: instruction/flag/memory-ready inputs and all control strobes.
interface mc_controller_ws_if;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite;
   logic        MemWrite;
   logic        RegWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic [1:0]  RegSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [2:0]  ALUControl;
   logic        MulEn;
   logic        opMul;
   logic [3:0]  Flags;
   logic        Undef;
   logic [3:0]  state;

   modport master (
      output Instr, ALUFlags, MemReady,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, MulEn, opMul, Flags, Undef, state
   );

   modport slave (
      input  Instr, ALUFlags, MemReady,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, MulEn, opMul, Flags, Undef, state
   );
endinterface

// File: rtl/mc_controller_ws_cond_unit.sv
// NZCV flag register, condition evaluation against the registered flags, and
// CondEx gating of the architectural write strobes.
module cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic [1:0] flag_w_i,
   input  logic       pcs_i,
   input  logic       reg_w_i,
   input  logic       mem_w_i,
   input  logic       next_pc_i,
   output logic       pc_write_o,
   output logic       reg_write_o,
   output logic       mem_write_o,
   output logic [3:0] flags_o
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ex;

   assign cond_ex = cond_check(cond_i, flags_q);

   always_comb begin
      flags_d = flags_q;
      if (flag_w_i[1] && cond_ex) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0] && cond_ex) flags_d[1:0] = alu_flags_i[1:0];
   end

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) flags_q <= '0;
      else       flags_q <= flags_d;
   end

   assign pc_write_o  = next_pc_i | (pcs_i & cond_ex);
   assign reg_write_o = reg_w_i & cond_ex;
   assign mem_write_o = mem_w_i & cond_ex;
   assign flags_o     = flags_q;

endmodule

// File: rtl/mc_controller_ws.sv
// Multicycle ARM control unit: main FSM with memory wait states, iterative multiply
// sequencing, ALU decoder and undefined-op trap; flag handling lives in cond_unit.
module mc_controller_ws
   import mc_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter bit MUL_EN     = 1'b1,
   parameter int CNT_W      = 3
) (
   input  logic               clk,
   input  logic               reset,
   mc_controller_ws_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cmd;
   logic       is_mul;
   logic       unused_instr;

   alu_ctrl_e  alu_dec, alu_control;
   logic       no_write, s_bit, arith;

   logic       ir_write, next_pc, adr_src, alu_src_a, reg_w, mem_w, branch;
   logic       mul_en, op_mul, undef, pcs;
   logic [1:0] alu_src_b, result_src, flag_w;
   logic       pc_write, reg_write, mem_write;

   assign op           = bus.Instr[27:26];
   assign funct        = bus.Instr[25:20];
   assign cmd          = funct[4:1];
   assign is_mul       = MUL_EN && (bus.Instr[7:4] == 4'b1001) && (cmd == 4'b0000);
   assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

   always_comb begin
      alu_dec  = ALU_AND;
      no_write = 1'b0;
      case (cmd)
         CMD_ADD: alu_dec = ALU_ADD;
         CMD_SUB: alu_dec = ALU_SUB;
         CMD_ORR: alu_dec = ALU_ORR;
         CMD_CMP: begin
            alu_dec  = ALU_SUB;
            no_write = 1'b1;
         end
         default: alu_dec = ALU_AND;
      endcase
      s_bit = funct[0] | (cmd == CMD_CMP);
      arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ir_write    = 1'b0;
      next_pc     = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = ALU_ADD;
      reg_w       = 1'b0;
      mem_w       = 1'b0;
      branch      = 1'b0;
      flag_w      = 2'b00;
      mul_en      = 1'b0;
      op_mul      = 1'b0;
      undef       = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = bus.MemReady;
            next_pc    = bus.MemReady;
            if (bus.MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               2'b11: begin
                  undef   = 1'b1;
                  state_d = S_FETCH;
               end
               default: state_d = funct[5] ? S_EXECI : (is_mul ? S_MULEX : S_EXECR);
            endcase
         end
         S_MEMADR: begin
            alu_src_b = 2'b01;
            state_d   = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
            if (bus.MemReady) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = bus.MemReady;
            if (bus.MemReady) state_d = S_FETCH;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            alu_control = alu_dec;
            flag_w      = {s_bit, s_bit & arith};
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w   = ~no_write;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MULEX: begin
            mul_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_MULWB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_MULWB: begin
            op_mul      = 1'b1;
            reg_w       = 1'b1;
            alu_control = ALU_MUL;
            flag_w      = {funct[0], 1'b0};
            state_d     = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign pcs = branch | (reg_w & (bus.Instr[15:12] == 4'hF));

   cond_unit u_cond (
      .clk         (clk),
      .reset       (reset),
      .cond_i      (bus.Instr[31:28]),
      .alu_flags_i (bus.ALUFlags),
      .flag_w_i    (flag_w),
      .pcs_i       (pcs),
      .reg_w_i     (reg_w),
      .mem_w_i     (mem_w),
      .next_pc_i   (next_pc),
      .pc_write_o  (pc_write),
      .reg_write_o (reg_write),
      .mem_write_o (mem_write),
      .flags_o     (bus.Flags)
   );

   // FETCH raises IRWrite from MemReady alone, so strobes are masked while reset is held.
   assign bus.IRWrite    = ir_write  & ~reset;
   assign bus.PCWrite    = pc_write  & ~reset;
   assign bus.MemWrite   = mem_write & ~reset;
   assign bus.RegWrite   = reg_write & ~reset;
   assign bus.MulEn      = mul_en    & ~reset;
   assign bus.opMul      = op_mul    & ~reset;
   assign bus.Undef      = undef     & ~reset;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = op;
   assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
   assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller_ws.sv
// Directed-vector bench for mc_controller_ws: each instruction is walked state by state
// against hand-derived controls, including wait states, multiply latency and reset.
module tb_mc_controller_ws;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   ir_cnt = 0, pc_cnt = 0, mul_cnt = 0;
   int   ir0, pc0, mul0;

   mc_controller_ws_if bus ();

   mc_controller_ws #(
      .MUL_CYCLES (4),
      .MUL_EN     (1'b1),
      .CNT_W      (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.IRWrite) ir_cnt++;
      if (bus.PCWrite) pc_cnt++;
      if (bus.MulEn)   mul_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From FETCH: run a MUL through DECODE, four MULEX cycles and MULWB, back to FETCH.
   task automatic run_mul(input string tag, input logic [31:0] instr, input int exp_rw);
      bus.Instr = instr;
      #1;
      mul0 = mul_cnt;
      cyc();
      check({tag, "_decode"}, 32'(bus.state), 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check({tag, "_mulex_state"}, 32'(bus.state), 10);
         check({tag, "_mulex_en"}, 32'(bus.MulEn), 1);
      end
      cyc();
      check({tag, "_mulwb_state"}, 32'(bus.state), 11);
      check({tag, "_mulwb_opmul"}, 32'(bus.opMul), 1);
      check({tag, "_mulwb_alu"}, 32'(bus.ALUControl), 'h4);
      check({tag, "_mulwb_regwrite"}, 32'(bus.RegWrite), 32'(exp_rw));
      check({tag, "_mulwb_mulen"}, 32'(bus.MulEn), 0);
      cyc();
      check({tag, "_back_fetch"}, 32'(bus.state), 0);
      check({tag, "_mulen_cycles"}, 32'(mul_cnt - mul0), 4);
   endtask

   initial begin
      reset        = 1'b1;
      bus.Instr    = 32'hE0821003;
      bus.ALUFlags = 4'b0000;
      bus.MemReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_state", 32'(bus.state), 0);
      check("rst_flags", 32'(bus.Flags), 0);
      check("rst_irwrite", 32'(bus.IRWrite), 0);
      check("rst_pcwrite", 32'(bus.PCWrite), 0);
      check("rst_regwrite", 32'(bus.RegWrite), 0);

      // ADD R1,R2,R3
      reset = 1'b0;
      #1;
      check("add_fetch_state", 32'(bus.state), 0);
      check("add_fetch_irwrite", 32'(bus.IRWrite), 1);
      check("add_fetch_pcwrite", 32'(bus.PCWrite), 1);
      cyc(); check("add_decode", 32'(bus.state), 1);
      check("add_decode_regwrite", 32'(bus.RegWrite), 0);
      cyc(); check("add_execr", 32'(bus.state), 6);
      check("add_execr_alu", 32'(bus.ALUControl), 0);
      check("add_execr_regwrite", 32'(bus.RegWrite), 0);
      cyc(); check("add_aluwb", 32'(bus.state), 8);
      check("add_aluwb_regwrite", 32'(bus.RegWrite), 1);
      check("add_aluwb_pcwrite", 32'(bus.PCWrite), 0);
      cyc(); check("add_fetch2", 32'(bus.state), 0);

      // LDR R2,[R1] with wait states in FETCH (3) and MEMRD (2)
      bus.Instr    = 32'hE5912000;
      bus.MemReady = 1'b0;
      #1;
      ir0 = ir_cnt;
      pc0 = pc_cnt;
      for (int i = 0; i < 3; i++) begin
         check("ldr_fetch_wait_state", 32'(bus.state), 0);
         check("ldr_fetch_wait_ir", 32'(bus.IRWrite), 0);
         cyc();
      end
      bus.MemReady = 1'b1;
      #1;
      check("ldr_fetch_ready_state", 32'(bus.state), 0);
      check("ldr_fetch_ready_ir", 32'(bus.IRWrite), 1);
      cyc(); check("ldr_decode", 32'(bus.state), 1);
      cyc(); check("ldr_memadr", 32'(bus.state), 2);
      check("ldr_memadr_srcb", 32'(bus.ALUSrcB), 1);
      cyc();
      bus.MemReady = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("ldr_memrd_wait_state", 32'(bus.state), 3);
         check("ldr_memrd_adrsrc", 32'(bus.AdrSrc), 1);
         cyc();
      end
      bus.MemReady = 1'b1;
      #1;
      check("ldr_memrd_ready_state", 32'(bus.state), 3);
      cyc(); check("ldr_memwb", 32'(bus.state), 4);
      check("ldr_memwb_regwrite", 32'(bus.RegWrite), 1);
      check("ldr_memwb_resultsrc", 32'(bus.ResultSrc), 1);
      cyc(); check("ldr_fetch", 32'(bus.state), 0);
      check("ldr_irwrite_pulses", 32'(ir_cnt - ir0), 1);
      check("ldr_pcwrite_pulses", 32'(pc_cnt - pc0), 1);

      // STR R2,[R1] with one MEMWR wait state
      bus.Instr = 32'hE5812000;
      cyc(); cyc();
      cyc(); check("str_memwr", 32'(bus.state), 5);
      bus.MemReady = 1'b0;
      #1;
      check("str_wait_memwrite", 32'(bus.MemWrite), 0);
      cyc(); check("str_wait_state", 32'(bus.state), 5);
      bus.MemReady = 1'b1;
      #1;
      check("str_memwrite", 32'(bus.MemWrite), 1);
      cyc(); check("str_fetch", 32'(bus.state), 0);

      // SUBS R0,R0,R0 producing Z and C
      bus.Instr    = 32'hE0500000;
      bus.ALUFlags = 4'b0110;
      cyc();
      cyc(); check("subs_execr", 32'(bus.state), 6);
      check("subs_alu", 32'(bus.ALUControl), 1);
      cyc(); check("subs_aluwb", 32'(bus.state), 8);
      check("subs_flags", 32'(bus.Flags), 'h6);
      check("subs_regwrite", 32'(bus.RegWrite), 1);
      cyc();

      // ADDEQ R1,R1,#1 (taken)
      bus.Instr    = 32'h02811001;
      bus.ALUFlags = 4'b0000;
      cyc();
      cyc(); check("addeq_execi", 32'(bus.state), 7);
      check("addeq_srcb", 32'(bus.ALUSrcB), 1);
      check("addeq_alu", 32'(bus.ALUControl), 0);
      cyc(); check("addeq_regwrite", 32'(bus.RegWrite), 1);
      cyc();

      // ADDNE R1,R1,#1 (not taken)
      bus.Instr = 32'h12811001;
      cyc(); cyc();
      cyc(); check("addne_aluwb", 32'(bus.state), 8);
      check("addne_regwrite", 32'(bus.RegWrite), 0);
      check("addne_flags_kept", 32'(bus.Flags), 'h6);
      cyc();

      run_mul("mul", 32'hE0040695, 1);
      run_mul("mulne", 32'h10040695, 0);

      // B with cond=1111 never writes the PC; BAL does
      bus.Instr = 32'hFA000000;
      cyc();
      cyc(); check("bnv_branch", 32'(bus.state), 9);
      check("bnv_pcwrite", 32'(bus.PCWrite), 0);
      cyc();
      bus.Instr = 32'hEA000000;
      cyc();
      cyc(); check("bal_branch", 32'(bus.state), 9);
      check("bal_pcwrite", 32'(bus.PCWrite), 1);
      cyc();

      // Undefined op class
      bus.Instr = 32'hEC000000;
      #1;
      check("undef_fetch_quiet", 32'(bus.Undef), 0);
      cyc(); check("undef_pulse", 32'(bus.Undef), 1);
      cyc(); check("undef_next_fetch", 32'(bus.state), 0);
      check("undef_cleared", 32'(bus.Undef), 0);

      // Reset during the second MULEX cycle
      bus.Instr = 32'hE0040695;
      cyc(); cyc();
      cyc(); check("rstmul_mulex2", 32'(bus.state), 10);
      reset = 1'b1;
      #1;
      check("rstmul_state", 32'(bus.state), 0);
      check("rstmul_flags", 32'(bus.Flags), 0);
      check("rstmul_mulen", 32'(bus.MulEn), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstmul_fetch", 32'(bus.state), 0);
      run_mul("mul_after_rst", 32'hE0040695, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
